// File: rtl/die_roll_presenter.sv
// rtl/die_roll_presenter.sv - debounced roll button, timed tumble animation, latched die result and display
module die_roll_presenter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TUMBLE_STEPS    = 8,
    parameter int STEP_CYCLES     = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       roll_btn,
    input  logic [7:0] die_val,
    output logic [6:0] seg,
    output logic [6:0] pips,
    output logic       rolling,
    output logic [2:0] result,
    output logic       result_valid
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int FW = (TUMBLE_STEPS > 1) ? $clog2(TUMBLE_STEPS) : 1;
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(TUMBLE_STEPS - 1);

    typedef enum logic [1:0] {IDLE, TUMBLE, CAPTURE, SHOW} state_t;

    state_t        state, state_next;
    logic          btn_meta, btn_s;
    logic [DW-1:0] deb_cnt;
    logic          deb, deb_d;
    logic          press;
    logic [SW-1:0] step;
    logic [FW-1:0] frame;
    logic [2:0]    disp;
    logic [6:0]    seg_d, pips_d;
    logic          die_ok, step_last, frame_last;
    logic          start, frame_tick, capture;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= roll_btn;
            btn_s    <= btn_meta;
        end
    end

    // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            deb     <= 1'b0;
            deb_d   <= 1'b0;
        end else begin
            deb_d <= deb;
            if (btn_s == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    assign press      = deb & ~deb_d;
    assign die_ok     = (die_val != 8'd0) && (die_val <= 8'd6);
    assign step_last  = (step == STEP_LAST);
    assign frame_last = (frame == FRAME_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (press) state_next = TUMBLE;
            TUMBLE:  if (step_last && frame_last) state_next = CAPTURE;
            CAPTURE: if (die_ok) state_next = SHOW;
            SHOW:    if (press) state_next = TUMBLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start      = 1'b0;
        frame_tick = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE, SHOW: start      = press;
            TUMBLE:     frame_tick = step_last;
            CAPTURE:    capture    = die_ok;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step         <= '0;
            frame        <= '0;
            disp         <= 3'd0;
            result       <= 3'd0;
            result_valid <= 1'b0;
            rolling      <= 1'b0;
            seg          <= 7'd0;
            pips         <= 7'd0;
        end else begin
            result_valid <= capture;
            rolling      <= (state == TUMBLE) || (state == CAPTURE);
            seg          <= seg_d;
            pips         <= pips_d;
            if (start) begin
                step  <= '0;
                frame <= '0;
            end else if (state == TUMBLE) begin
                if (step_last) begin
                    step  <= '0;
                    frame <= frame_last ? frame : frame + FW'(1);
                end else begin
                    step <= step + SW'(1);
                end
            end
            // Invalid values on a frame boundary leave the previous frame on show
            if ((frame_tick || capture) && die_ok) disp <= die_val[2:0];
            if (capture) result <= die_val[2:0];
        end
    end

    always_comb begin
        seg_d  = 7'b0000000;
        pips_d = 7'b0000000;
        case (disp)
            3'd1: begin seg_d = 7'b0000110; pips_d = 7'b0001000; end
            3'd2: begin seg_d = 7'b1011011; pips_d = 7'b1000001; end
            3'd3: begin seg_d = 7'b1001111; pips_d = 7'b1001001; end
            3'd4: begin seg_d = 7'b1100110; pips_d = 7'b1100011; end
            3'd5: begin seg_d = 7'b1101101; pips_d = 7'b1101011; end
            3'd6: begin seg_d = 7'b1111101; pips_d = 7'b1110111; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_die_roll_presenter.sv
// tb/tb_die_roll_presenter.sv - directed vector bench for die_roll_presenter
module tb_die_roll_presenter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       roll_btn;
    logic [7:0] die_val;
    logic [6:0] seg, pips;
    logic       rolling;
    logic [2:0] result;
    logic       result_valid;

    always #5 clk = ~clk;

    die_roll_presenter #(
        .DEBOUNCE_CYCLES(4),
        .TUMBLE_STEPS   (3),
        .STEP_CYCLES    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .roll_btn    (roll_btn),
        .die_val     (die_val),
        .seg         (seg),
        .pips        (pips),
        .rolling     (rolling),
        .result      (result),
        .result_valid(result_valid)
    );

    typedef struct {
        logic [7:0] die;
        logic [6:0] seg;
        logic [6:0] pips;
    } vec_t;

    vec_t       vecs[6];
    int         checks = 0;
    int         failures = 0;
    int         rv_count = 0;
    int         rv0;
    bit         cyc_mode = 1'b0;
    bit         bad, seen, seg_nz, ok;
    logic [7:0] die_at_edge = 8'd0;
    logic [2:0] old_res;
    int         idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock: drive after the edge, return at the falling edge for sampling
    task automatic step();
        @(posedge clk);
        die_at_edge = die_val;
        #1;
        if (cyc_mode) die_val = (die_val >= 8'd6 || die_val == 8'd0) ? 8'd1 : die_val + 8'd1;
        @(negedge clk);
        if (result_valid === 1'b1) rv_count++;
    endtask

    task automatic wait_rv(input int max_cycles, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            step();
            if (result_valid === 1'b1) got = 1'b1;
        end
    endtask

    initial begin
        vecs[0] = '{8'd1, 7'b0000110, 7'b0001000};
        vecs[1] = '{8'd2, 7'b1011011, 7'b1000001};
        vecs[2] = '{8'd3, 7'b1001111, 7'b1001001};
        vecs[3] = '{8'd4, 7'b1100110, 7'b1100011};
        vecs[4] = '{8'd5, 7'b1101101, 7'b1101011};
        vecs[5] = '{8'd6, 7'b1111101, 7'b1110111};

        rst_n = 1'b0; roll_btn = 1'b0; die_val = 8'd3;
        repeat (3) step();
        check("reset_seg", 32'(seg), 0);
        check("reset_pips", 32'(pips), 0);
        check("reset_result", 32'(result), 0);
        check("reset_rolling", 32'(rolling), 0);
        check("reset_rv", 32'(result_valid), 0);
        rst_n = 1'b1;

        bad = 1'b0;
        repeat (20) begin
            step();
            if (seg != 7'd0 || pips != 7'd0 || result != 3'd0 || rolling || result_valid) bad = 1'b1;
        end
        check("idle_quiet", 32'(bad), 0);
        check("idle_rv_count", 32'(rv_count), 0);

        roll_btn = 1'b1; step(); step(); roll_btn = 1'b0;
        bad = 1'b0;
        repeat (15) begin step(); if (rolling !== 1'b0) bad = 1'b1; end
        check("glitch_no_roll", 32'(bad), 0);
        check("glitch_rv_count", 32'(rv_count), 0);

        cyc_mode = 1'b1; roll_btn = 1'b1; seen = 1'b0; seg_nz = 1'b0; rv0 = rv_count;
        repeat (10) begin step(); if (rolling) seen = 1'b1; if (seg != 7'd0) seg_nz = 1'b1; end
        roll_btn = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (result_valid === 1'b1) ok = 1'b1;
            else if (seg != 7'd0) seg_nz = 1'b1;
        end
        check("t3_rv_seen", 32'(ok), 1);
        check("t3_rolling_rose", 32'(seen), 1);
        check("t3_frames_shown", 32'(seg_nz), 1);
        check("t3_result", 32'(result), 32'(die_at_edge[2:0]));
        idx = (die_at_edge >= 8'd1 && die_at_edge <= 8'd6) ? int'(die_at_edge) - 1 : 0;
        step();
        check("t3_pulse_width", 32'(result_valid), 0);
        check("t3_seg", 32'(seg), 32'(vecs[idx].seg));
        check("t3_pips", 32'(pips), 32'(vecs[idx].pips));
        check("t3_rolling_fell", 32'(rolling), 0);
        cyc_mode = 1'b0; old_res = result;
        repeat (12) step();
        check("t3_single_pulse", 32'(rv_count - rv0), 1);

        die_val = 8'd0; roll_btn = 1'b1; rv0 = rv_count; bad = 1'b0;
        repeat (18) begin step(); if (result !== old_res) bad = 1'b1; end
        check("t4_in_capture", 32'(rolling), 1);
        check("t4_result_held", 32'(bad), 0);
        die_val = 8'd7; step();
        die_val = 8'd255; step();
        die_val = 8'd0; repeat (3) step();
        check("t4_no_pulse_invalid", 32'(rv_count - rv0), 0);
        check("t4_still_rolling", 32'(rolling), 1);
        die_val = 8'd4;
        wait_rv(5, ok);
        check("t4_rv_seen", 32'(ok), 1);
        check("t4_result", 32'(result), 4);
        step();
        check("t4_seg", 32'(seg), 32'(7'b1100110));
        check("t4_pips", 32'(pips), 32'(7'b1100011));
        roll_btn = 1'b0;
        repeat (12) step();
        check("t4_single_pulse", 32'(rv_count - rv0), 1);

        die_val = 8'd0; roll_btn = 1'b1; rv0 = rv_count;
        repeat (18) step();
        roll_btn = 1'b0; repeat (10) step();
        roll_btn = 1'b1; repeat (10) step();
        check("t5_press_ignored", 32'(rolling), 1);
        check("t5_no_pulse_yet", 32'(rv_count - rv0), 0);
        die_val = 8'd5; step();
        check("t5_immediate_capture", 32'(result_valid), 1);
        check("t5_result", 32'(result), 5);
        roll_btn = 1'b0; die_val = 8'd0;
        repeat (12) step();
        check("t5_single_pulse", 32'(rv_count - rv0), 1);
        roll_btn = 1'b1;
        repeat (18) step();
        check("t5_reroll_rolling", 32'(rolling), 1);
        check("t5_old_result_held", 32'(result), 5);
        die_val = 8'd6; step();
        check("t5_reroll_rv", 32'(result_valid), 1);
        check("t5_reroll_result", 32'(result), 6);
        roll_btn = 1'b0;
        repeat (12) step();

        die_val = 8'd3; roll_btn = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin step(); if (rolling === 1'b1) ok = 1'b1; end
        check("t6_rolling_before_reset", 32'(ok), 1);
        rst_n = 1'b0; roll_btn = 1'b0; rv0 = rv_count;
        step();
        check("t6_seg", 32'(seg), 0);
        check("t6_pips", 32'(pips), 0);
        check("t6_result", 32'(result), 0);
        check("t6_rolling", 32'(rolling), 0);
        check("t6_rv", 32'(result_valid), 0);
        rst_n = 1'b1;
        repeat (15) step();
        check("t6_no_pulse_after_abort", 32'(rv_count - rv0), 0);
        check("t6_idle_after_abort", 32'(rolling), 0);

        for (int i = 0; i < 6; i++) begin
            die_val = vecs[i].die; roll_btn = 1'b1;
            wait_rv(40, ok);
            check($sformatf("vec%0d_rv_seen", i), 32'(ok), 1);
            check($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].die));
            step();
            check($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].seg));
            check($sformatf("vec%0d_pips", i), 32'(pips), 32'(vecs[i].pips));
            roll_btn = 1'b0;
            repeat (12) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
